mac_violation_handler: RTL and testbench
========================================

// Module: mac_violation_handler
// PURPOSE
//  Response end of the protected-section access checker. Consumes the checker's
//  per-cause violation strobes, records the cause, the PC and the faulting
//  address, and drives a stretched system-reset pulse to the openMSP430.
//  Fault records are cleared only by reset_n, so they survive the reset this
//  block issues. Software reads and clears them over the peripheral bus.
// PARAMETERS
//  BASE_ADDR      14'h00C8  word address of reg 0 (byte 0x0190); regs at BASE_ADDR+0..3
//  RST_CYCLES     8         cycles sys_rst stays high per violation; legal range 1..255
//  HOLDOFF_CYCLES 4         cycles after release during which new violations are not captured; 0..255
// PORTS
//  clk         in   1   system clock
//  reset_n     in   1   asynchronous active-low reset
//  viol_data   in   1   data-section access from outside the protected text
//  viol_text   in   1   text-section fetch/read from outside the protected text
//  viol_write  in   1   write to the protected text from inside the protected text
//  viol_jump   in   1   entry into the protected text at a non-entry address
//  pc          in   16  current CPU program counter
//  data_addr   in   16  current data bus address
//  code_addr   in   16  current code bus address
//  per_addr    in   14  peripheral word address
//  per_din     in   16  peripheral write data
//  per_en      in   1   peripheral access enable
//  per_we      in   2   peripheral byte write enables {hi,lo}
//  per_dout    out  16  peripheral read data; 0 when not selected or not reading
//  sys_rst     out  1   active-high system reset request to the CPU (registered)
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, sys_rst=0, all regs=0, counters=0, per_dout=0.
//  viol = |{viol_jump,viol_write,viol_text,viol_data}; sampled on the rising edge of clk.
//  FSM:
//   IDLE    : viol -> capture; next ASSERT. sys_rst=1 from the next cycle (latency 1).
//   ASSERT  : sys_rst=1 for exactly RST_CYCLES cycles.
//             Then next HOLDOFF, or IDLE if HOLDOFF_CYCLES=0.
//   HOLDOFF : sys_rst=0 for HOLDOFF_CYCLES cycles, then next IDLE.
//  Capture (IDLE only):
//   STATUS[3:0]   <= {jump,write,text,data}, overwritten on each capture.
//   STATUS[7:4]   |= same bits (sticky).
//   FAULT_PC      <= pc.
//   FAULT_ADDR    <= viol_data ? data_addr : code_addr.
//   COUNT         <= COUNT+1, saturating at 16'hFFFF.
//  Any viol in ASSERT or HOLDOFF: no capture and no COUNT change; set STATUS[8] (OVR).
//  Register map, word offsets from BASE_ADDR:
//   0 STATUS: [3:0] last cause, [7:4] sticky cause, [8] OVR, [9] BUSY (state!=IDLE,
//     read-only), [15:10]=0. Bits [8:0] are write-1-to-clear.
//     per_we[0] affects [7:0]; per_we[1] affects [8].
//   1 FAULT_PC    read-only.
//   2 FAULT_ADDR  read-only.
//   3 COUNT       any write with per_we!=0 clears it to 0.
//  Read: per_dout is combinational, = reg when per_en & per_we==0 & addr hit, else 0.
//  Simultaneous capture and W1C on the same bit: set wins.
//  Simultaneous capture and COUNT clear: COUNT=1.
//  Bus accesses stay live in every state; sys_rst does not reset this block.
//  reset_n asserted mid-ASSERT: sys_rst drops immediately; records cleared; FSM to IDLE.
// TESTING
//  1. reset_n low, then release; no viol
//     -> sys_rst=0, all four reads return 0, BUSY=0.
//  2. viol_data=1 for one cycle, pc=16'h8010, data_addr=16'h0600
//     -> sys_rst high cycles 1..8; STATUS=16'h0211 while ASSERT/HOLDOFF;
//        FAULT_PC=8010, FAULT_ADDR=0600, COUNT=1; STATUS=16'h0011 back in IDLE.
//  3. viol_jump during ASSERT, then viol_text during HOLDOFF
//     -> no new capture, COUNT stays 1, STATUS[8]=1;
//        W1C write 16'h0100 with per_we=2'b10 clears OVR only.
//  4. COUNT preset to FFFF by 16'hFFFF captures (or force), then one more viol
//     -> COUNT stays FFFF; a COUNT write and a capture in the same cycle -> COUNT=1.
//  5. W1C write 16'h00FF to STATUS in the same cycle a viol_text capture occurs
//     -> STATUS[3:0]=4'h2, STATUS[7:4]=4'h2; all other bits 0.
//  6. reset_n pulsed low at ASSERT cycle 3
//     -> sys_rst=0 asynchronously; all regs 0; the next viol is captured normally.

Source files
------------

// File: rtl/mac_violation_handler.sv
// mac_violation_handler
//   Response end of the protected-section access checker. Records the cause,
//   PC and faulting address of a violation, then drives a stretched system
//   reset pulse to the CPU followed by a hold-off window. Fault records are
//   cleared only by reset_n, so they survive the reset issued here. Software
//   reads and clears the records over the peripheral bus.
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   viol_data/text/
//   viol_write/jump       per-cause violation strobes from the checker
//   pc, data_addr,
//   code_addr             CPU state captured on a violation
//   per_addr/din/en/we    peripheral bus request (word address, byte enables)
//   per_dout              peripheral read data, 0 when not selected/reading
//   sys_rst               registered active-high reset request to the CPU
module mac_violation_handler #(
  parameter logic [13:0] BASE_ADDR      = 14'h00C8,
  parameter int unsigned RST_CYCLES     = 8,
  parameter int unsigned HOLDOFF_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        viol_data,
  input  logic        viol_text,
  input  logic        viol_write,
  input  logic        viol_jump,
  input  logic [15:0] pc,
  input  logic [15:0] data_addr,
  input  logic [15:0] code_addr,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic        sys_rst
);

  typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;

  localparam logic [7:0] RST_LAST  = 8'(RST_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST = (HOLDOFF_CYCLES == 0) ? 8'd0 : 8'(HOLDOFF_CYCLES - 1);

  state_t      state, state_next;
  logic [7:0]  cnt, cnt_next;

  logic [3:0]  last_cause, sticky_cause;
  logic        ovr;
  logic [15:0] fault_pc, fault_addr, count;

  logic [3:0]  cause;
  logic        viol, capture, ovr_set;
  logic [13:0] off;
  logic        hit, rd, wr;
  logic [7:0]  clr_lo;
  logic        clr_ovr, count_clr;
  logic [15:0] count_next;
  logic        unused_din;

  assign cause      = {viol_jump, viol_write, viol_text, viol_data};
  assign viol       = |cause;
  assign capture    = viol && (state == IDLE);
  assign ovr_set    = viol && (state != IDLE);
  assign unused_din = ^per_din[15:9];

  // Offset-based decode works for any BASE_ADDR, aligned or not.
  assign off = per_addr - BASE_ADDR;
  assign hit = (off < 14'd4);
  assign rd  = per_en && (per_we == 2'b00) && hit;
  assign wr  = per_en && (per_we != 2'b00) && hit;

  assign clr_lo    = (wr && off[1:0] == 2'd0 && per_we[0]) ? per_din[7:0] : 8'h00;
  assign clr_ovr   = wr && off[1:0] == 2'd0 && per_we[1] && per_din[8];
  assign count_clr = wr && off[1:0] == 2'd3;

  // Capture overrides a same-cycle clear: the clear is applied first, then the increment.
  always_comb begin
    count_next = count_clr ? 16'h0000 : count;
    if (capture) begin
      if (count_clr)
        count_next = 16'h0001;
      else if (count != 16'hFFFF)
        count_next = count + 16'h0001;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (viol) begin
          state_next = ASSERT;
          cnt_next   = '0;
        end
      end
      ASSERT: begin
        if (cnt == RST_LAST) begin
          state_next = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      HOLDOFF: begin
        if (cnt == HOLD_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      sys_rst <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      sys_rst <= (state_next == ASSERT);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_cause   <= '0;
      sticky_cause <= '0;
      ovr          <= 1'b0;
      fault_pc     <= '0;
      fault_addr   <= '0;
      count        <= '0;
    end else begin
      last_cause   <= capture ? cause : (last_cause & ~clr_lo[3:0]);
      sticky_cause <= (sticky_cause & ~clr_lo[7:4]) | (capture ? cause : 4'h0);
      ovr          <= (ovr & ~clr_ovr) | ovr_set;
      count        <= count_next;
      if (capture) begin
        fault_pc   <= pc;
        fault_addr <= viol_data ? data_addr : code_addr;
      end
    end
  end

  always_comb begin
    per_dout = '0;
    if (rd) begin
      case (off[1:0])
        2'd0:    per_dout = {6'b0, (state != IDLE), ovr, sticky_cause, last_cause};
        2'd1:    per_dout = fault_pc;
        2'd2:    per_dout = fault_addr;
        default: per_dout = count;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_violation_handler.sv
module tb_mac_violation_handler;

  localparam int          RST  = 8;
  localparam int          HOLD = 4;
  localparam logic [13:0] BASE = 14'h00C8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        viol_data, viol_text, viol_write, viol_jump;
  logic [15:0] pc, data_addr, code_addr;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic        sys_rst;

  always #5 clk = ~clk;

  mac_violation_handler #(
    .BASE_ADDR(BASE),
    .RST_CYCLES(RST),
    .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .viol_data(viol_data), .viol_text(viol_text),
    .viol_write(viol_write), .viol_jump(viol_jump),
    .pc(pc), .data_addr(data_addr), .code_addr(code_addr),
    .per_addr(per_addr), .per_din(per_din), .per_en(per_en), .per_we(per_we),
    .per_dout(per_dout), .sys_rst(sys_rst)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: busy is the number of cycles left until the block
  // accepts violations again; reset is requested while busy exceeds HOLD.
  int          m_busy;
  logic [3:0]  m_last, m_sticky;
  logic        m_ovr;
  logic [15:0] m_pc, m_addr, m_count;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_busy = 0; m_last = 0; m_sticky = 0; m_ovr = 0;
    m_pc = 0; m_addr = 0; m_count = 0;
  endtask

  function automatic logic [15:0] m_read();
    logic [13:0] o;
    o = per_addr - BASE;
    if (!(per_en && per_we == 2'b00 && o < 14'd4)) return 16'h0000;
    case (o[1:0])
      2'd0:    return {6'b0, m_busy != 0, m_ovr, m_sticky, m_last};
      2'd1:    return m_pc;
      2'd2:    return m_addr;
      default: return m_count;
    endcase
  endfunction

  task automatic m_step();
    logic [3:0]  v;
    logic [13:0] o;
    logic        wr, cov, cclr, cap;
    logic [7:0]  clr;
    v    = {viol_jump, viol_write, viol_text, viol_data};
    o    = per_addr - BASE;
    wr   = per_en && per_we != 2'b00 && o < 14'd4;
    clr  = (wr && o == 0 && per_we[0]) ? per_din[7:0] : 8'h00;
    cov  = wr && o == 0 && per_we[1] && per_din[8];
    cclr = wr && o == 3;
    cap  = (v != 0) && m_busy == 0;
    if (cap) begin
      m_last  = v;
      m_pc    = pc;
      m_addr  = viol_data ? data_addr : code_addr;
      m_count = cclr ? 16'd1 : (m_count == 16'hFFFF ? m_count : m_count + 16'd1);
    end else begin
      m_last = m_last & ~clr[3:0];
      if (cclr) m_count = 0;
    end
    m_sticky = (m_sticky & ~clr[7:4]) | (cap ? v : 4'h0);
    m_ovr    = (m_ovr & ~cov) | ((v != 0) && m_busy != 0);
    if (cap) m_busy = RST + HOLD;
    else if (m_busy > 0) m_busy--;
  endtask

  // One bus/violation cycle, entered just after a falling edge.
  task automatic step(input logic [3:0] v, input logic en, input logic [13:0] a,
                      input logic [1:0] we, input logic [15:0] din, output logic [15:0] rd);
    {viol_jump, viol_write, viol_text, viol_data} = v;
    per_en = en; per_addr = a; per_we = we; per_din = din;
    #1;
    rd = per_dout;
    check("per_dout", per_dout, m_read());
    check("sys_rst", {15'b0, sys_rst}, {15'b0, m_busy > HOLD});
    @(posedge clk);
    if (reset_n) m_step();
    @(negedge clk);
  endtask

  task automatic idle();
    logic [15:0] rd;
    step(4'h0, 1'b0, 14'h0, 2'b00, 16'h0, rd);
  endtask

  task automatic rd_reg(input logic [1:0] o, input logic [15:0] exp, input string name);
    logic [15:0] rd;
    step(4'h0, 1'b1, BASE + 14'(o), 2'b00, 16'h0, rd);
    check(name, rd, exp);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && m_busy != 0; i++) idle();
    if (m_busy != 0) begin
      errors++;
      $display("FAIL wait_idle: busy %0d expected 0", m_busy);
    end
  endtask

  logic [15:0] rdv;

  initial begin
    reset_n = 1'b0;
    {viol_jump, viol_write, viol_text, viol_data} = 4'h0;
    pc = 0; data_addr = 0; code_addr = 0;
    per_addr = 0; per_din = 0; per_en = 0; per_we = 0;
    m_reset();
    @(negedge clk); @(negedge clk);
    check("reset_sys_rst", {15'b0, sys_rst}, 16'h0);
    reset_n = 1'b1;

    // 1: clean state after reset
    idle();
    rd_reg(2'd0, 16'h0000, "t1_status");
    rd_reg(2'd1, 16'h0000, "t1_pc");
    rd_reg(2'd2, 16'h0000, "t1_addr");
    rd_reg(2'd3, 16'h0000, "t1_count");

    // 2: single data violation
    pc = 16'h8010; data_addr = 16'h0600; code_addr = 16'h1111;
    step(4'b0001, 1'b0, 14'h0, 2'b00, 16'h0, rdv);
    check("t2_sys_rst_high", {15'b0, sys_rst}, 16'h0001);
    rd_reg(2'd0, 16'h0211, "t2_status_busy");
    rd_reg(2'd1, 16'h8010, "t2_pc");
    rd_reg(2'd2, 16'h0600, "t2_addr");
    rd_reg(2'd3, 16'h0001, "t2_count");

    // 3: violations during ASSERT and HOLDOFF only set OVR
    step(4'b1000, 1'b0, 14'h0, 2'b00, 16'h0, rdv);
    for (int i = 0; i < 50 && m_busy > HOLD; i++) idle();
    check("t3_sys_rst_low", {15'b0, sys_rst}, 16'h0);
    step(4'b0010, 1'b0, 14'h0, 2'b00, 16'h0, rdv);
    rd_reg(2'd3, 16'h0001, "t3_count");
    rd_reg(2'd0, 16'h0311, "t3_status_ovr");
    step(4'h0, 1'b1, BASE, 2'b10, 16'h0100, rdv);
    wait_idle();
    rd_reg(2'd0, 16'h0011, "t3_status_idle");

    // 5: W1C of cause bits colliding with a text capture
    step(4'b0010, 1'b1, BASE, 2'b01, 16'h00FF, rdv);
    wait_idle();
    rd_reg(2'd0, 16'h0022, "t5_status");
    rd_reg(2'd3, 16'h0002, "t5_count");

    // 4: COUNT saturation and capture-vs-clear
    force dut.count = 16'hFFFE;
    #1 release dut.count;
    m_count = 16'hFFFE;
    step(4'b0001, 1'b0, 14'h0, 2'b00, 16'h0, rdv);
    wait_idle();
    step(4'b0100, 1'b0, 14'h0, 2'b00, 16'h0, rdv);
    wait_idle();
    rd_reg(2'd3, 16'hFFFF, "t4_count_sat");
    step(4'b0001, 1'b1, BASE + 14'd3, 2'b11, 16'h0, rdv);
    wait_idle();
    rd_reg(2'd3, 16'h0001, "t4_count_clr_cap");

    // 6: asynchronous reset in the middle of ASSERT
    code_addr = 16'h1234;
    step(4'b1000, 1'b0, 14'h0, 2'b00, 16'h0, rdv);
    idle(); idle();
    #2 reset_n = 1'b0;
    #1 check("t6_sys_rst_async", {15'b0, sys_rst}, 16'h0);
    m_reset();
    @(negedge clk);
    rd_reg(2'd0, 16'h0000, "t6_status_in_reset");
    reset_n = 1'b1;
    rd_reg(2'd3, 16'h0000, "t6_count_cleared");
    code_addr = 16'hABCD;
    step(4'b0100, 1'b0, 14'h0, 2'b00, 16'h0, rdv);
    rd_reg(2'd2, 16'hABCD, "t6_addr");
    rd_reg(2'd3, 16'h0001, "t6_count");
    wait_idle();

    // Randomised traffic against the model
    for (int n = 0; n < 4000; n++) begin
      logic [3:0]  v;
      logic        en;
      logic [13:0] a;
      logic [1:0]  we;
      v  = ($urandom_range(0, 6) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      en = $urandom_range(0, 1) == 1;
      a  = BASE - 14'd1 + 14'($urandom_range(0, 5));
      we = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      pc = 16'($urandom); data_addr = 16'($urandom); code_addr = 16'($urandom);
      step(v, en, a, we, 16'($urandom), rdv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
